// File: rtl/collatz_pkg.sv
// Shared types and constants for the Collatz engine.
package collatz_pkg;
  localparam int W_DEF  = 20;
  localparam int CW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_ZERO = 2'b01;
  localparam logic [1:0] ST_OVF  = 2'b10;
  localparam logic [1:0] ST_SAT  = 2'b11;
endpackage

// File: rtl/collatz_if.sv
// Request/result bundle of the Collatz engine; peak exists only with COLLATZ_PEAK_EN.
interface collatz_if #(
  parameter int W  = collatz_pkg::W_DEF,
  parameter int CW = collatz_pkg::CW_DEF
);
  logic          start;
  logic [W-1:0]  seed;
  logic          abort;
  logic          busy;
  logic          done;
  logic [CW-1:0] steps;
  logic [1:0]    status;
`ifdef COLLATZ_PEAK_EN
  logic [W-1:0]  peak;

  modport master (output start, seed, abort, input busy, done, steps, status, peak);
  modport slave  (input start, seed, abort, output busy, done, steps, status, peak);
`else
  modport master (output start, seed, abort, input busy, done, steps, status);
  modport slave  (input start, seed, abort, output busy, done, steps, status);
`endif
endinterface

// File: rtl/collatz_dp.sv
// Collatz datapath: value, step counter, status and optional peak (COLLATZ_PEAK_EN).
module collatz_dp
  import collatz_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [W-1:0]  seed_i,
  input  logic          step_i,
  input  logic          st_we_i,
  input  logic [1:0]    st_i,
  output logic          k_zero_o,
  output logic          k_one_o,
  output logic          sat_o,
  output logic          ovf_o,
  output logic [CW-1:0] steps_o,
  output logic [1:0]    status_o
`ifdef COLLATZ_PEAK_EN
  ,
  output logic [W-1:0]  peak_o
`endif
);
  logic [W-1:0]  k_q, k_d, k_nxt;
  logic [W+1:0]  k3;
  logic [CW-1:0] steps_q, steps_d;
  logic [1:0]    status_q, status_d;

  // 3k+1 carried two bits wider so an overflow shows up in the top bits
  always_comb begin
    k3    = ({2'b00, k_q} << 1) + {2'b00, k_q} + {{(W+1){1'b0}}, 1'b1};
    k_nxt = k_q[0] ? k3[W-1:0] : {1'b0, k_q[W-1:1]};
  end

  assign ovf_o    = k_q[0] & (|k3[W+1:W]);
  assign k_zero_o = (k_q == '0);
  assign k_one_o  = (k_q == W'(1));
  assign sat_o    = &steps_q;
  assign steps_o  = steps_q;
  assign status_o = status_q;

  always_comb begin
    k_d      = k_q;
    steps_d  = steps_q;
    status_d = status_q;
    if (load_i) begin
      k_d      = seed_i;
      steps_d  = '0;
      status_d = ST_OK;
    end else begin
      if (step_i) begin
        k_d     = k_nxt;
        steps_d = steps_q + CW'(1);
      end
      if (st_we_i) status_d = st_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q      <= '0;
      steps_q  <= '0;
      status_q <= ST_OK;
    end else begin
      k_q      <= k_d;
      steps_q  <= steps_d;
      status_q <= status_d;
    end
  end

`ifdef COLLATZ_PEAK_EN
  logic [W-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (load_i)                         peak_d = seed_i;
    else if (step_i && k_nxt > peak_q)  peak_d = k_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) peak_q <= '0;
    else        peak_q <= peak_d;
  end

  assign peak_o = peak_q;
`endif
endmodule

// File: rtl/collatz_engine.sv
// Collatz step engine: IDLE/RUN/DONE control over collatz_dp. Optional peak via COLLATZ_PEAK_EN.
module collatz_engine
  import collatz_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input logic   clk,
  input logic   rst_n,
  collatz_if.slave bus
);
  state_t     state_q, state_d;
  logic       load, step, st_we;
  logic [1:0] st;
  logic       k_zero, k_one, sat, ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Termination checks in RUN are priority ordered; abort overrides all of them
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    st_we   = 1'b0;
    st      = ST_OK;
    case (state_q)
      IDLE: if (bus.start) begin
        load    = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (k_zero) begin
          st_we   = 1'b1;
          st      = ST_ZERO;
          state_d = DONE;
        end else if (k_one) begin
          state_d = DONE;
        end else if (sat) begin
          st_we   = 1'b1;
          st      = ST_SAT;
          state_d = DONE;
        end else if (ovf) begin
          st_we   = 1'b1;
          st      = ST_OVF;
          state_d = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);

  collatz_dp #(.W(W), .CW(CW)) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load),
    .seed_i   (bus.seed),
    .step_i   (step),
    .st_we_i  (st_we),
    .st_i     (st),
    .k_zero_o (k_zero),
    .k_one_o  (k_one),
    .sat_o    (sat),
    .ovf_o    (ovf),
    .steps_o  (bus.steps),
    .status_o (bus.status)
`ifdef COLLATZ_PEAK_EN
    ,
    .peak_o   (bus.peak)
`endif
  );
endmodule

// File: tb/tb_collatz_engine.sv
// Bench for collatz_engine: three parameterizations checked against an arithmetic Collatz model.
module tb_collatz_engine;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  localparam int WS  [3] = '{20, 8, 20};
  localparam int CWS [3] = '{16, 16, 4};

  logic        start_a  [3];
  logic        abort_a  [3];
  logic [19:0] seed_a   [3];
  logic        busy_a   [3];
  logic        done_a   [3];
  logic [15:0] steps_a  [3];
  logic [1:0]  status_a [3];

  collatz_if #(.W(20), .CW(16)) if0 ();
  collatz_if #(.W(8),  .CW(16)) if1 ();
  collatz_if #(.W(20), .CW(4))  if2 ();

  collatz_engine #(.W(20), .CW(16)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  collatz_engine #(.W(8),  .CW(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  collatz_engine #(.W(20), .CW(4))  u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  assign if0.start = start_a[0];  assign if0.abort = abort_a[0];  assign if0.seed = seed_a[0];
  assign if1.start = start_a[1];  assign if1.abort = abort_a[1];  assign if1.seed = seed_a[1][7:0];
  assign if2.start = start_a[2];  assign if2.abort = abort_a[2];  assign if2.seed = seed_a[2];

  assign busy_a[0] = if0.busy;  assign done_a[0] = if0.done;
  assign busy_a[1] = if1.busy;  assign done_a[1] = if1.done;
  assign busy_a[2] = if2.busy;  assign done_a[2] = if2.done;
  assign steps_a[0] = if0.steps;
  assign steps_a[1] = if1.steps;
  assign steps_a[2] = {12'b0, if2.steps};
  assign status_a[0] = if0.status;
  assign status_a[1] = if1.status;
  assign status_a[2] = if2.status;

`ifdef COLLATZ_PEAK_EN
  logic [19:0] peak_a [3];
  assign peak_a[0] = if0.peak;
  assign peak_a[1] = {12'b0, if1.peak};
  assign peak_a[2] = if2.peak;
`endif

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Plain Collatz walk following the run rules; returns steps, status code and peak.
  function automatic void model(input longint sd, input int w, input int cw,
                                output int st, output int stat, output longint pk);
    longint k    = sd;
    longint lim  = (longint'(1) << w) - 1;
    longint smax = (longint'(1) << cw) - 1;
    st = 0; stat = 0; pk = sd;
    while (1) begin
      if (k == 0) begin stat = 1; break; end
      if (k == 1) break;
      if (st == smax) begin stat = 3; break; end
      if (k % 2 == 1) begin
        if (3 * k + 1 > lim) begin stat = 2; break; end
        k = 3 * k + 1;
      end else begin
        k = k / 2;
      end
      st++;
      if (k > pk) pk = k;
    end
  endfunction

  // Launch a run on DUT d; poke re-asserts start mid-run, co asserts abort with start.
  task automatic run_chk(input int d, input logic [19:0] sd, input bit poke, input bit co,
                         input string tag);
    int es, est, n;
    longint epk;
    bit seen;
    model(longint'(sd), WS[d], CWS[d], es, est, epk);
    @(negedge clk);
    seed_a[d] = sd; start_a[d] = 1'b1; abort_a[d] = co;
    @(posedge clk); #1;
    start_a[d] = 1'b0; abort_a[d] = 1'b0;
    chk({tag, ".busy"}, busy_a[d], 1);
    n = 0; seen = 0;
    while (!seen && n < 2000) begin
      if (poke && n == 3) begin start_a[d] = 1'b1; seed_a[d] = 20'd6; end
      @(posedge clk); #1;
      start_a[d] = 1'b0;
      n++;
      seen = done_a[d];
    end
    chk({tag, ".done_seen"}, seen, 1);
    chk({tag, ".latency"}, n, es + 1);
    chk({tag, ".steps"}, steps_a[d], es);
    chk({tag, ".status"}, status_a[d], est);
    chk({tag, ".busy_at_done"}, busy_a[d], 0);
`ifdef COLLATZ_PEAK_EN
    chk({tag, ".peak"}, peak_a[d], epk);
`endif
    @(posedge clk); #1;
    chk({tag, ".done_one_cycle"}, done_a[d], 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int es, est;
    longint epk;
    bit any_done;
    for (int i = 0; i < 3; i++) begin
      start_a[i] = 0; abort_a[i] = 0; seed_a[i] = '0;
    end
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d.busy", i),   busy_a[i],   0);
      chk($sformatf("rst%0d.done", i),   done_a[i],   0);
      chk($sformatf("rst%0d.steps", i),  steps_a[i],  0);
      chk($sformatf("rst%0d.status", i), status_a[i], 0);
`ifdef COLLATZ_PEAK_EN
      chk($sformatf("rst%0d.peak", i),   peak_a[i],   0);
`endif
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_chk(0, 20'd27,  0, 0, "s27");
    run_chk(0, 20'd1,   0, 0, "s1");
    run_chk(0, 20'd0,   0, 0, "s0");
    run_chk(1, 20'd255, 0, 0, "w8_s255");
    run_chk(1, 20'd7,   0, 0, "w8_s7");
    run_chk(2, 20'd27,  0, 0, "cw4_s27");
    run_chk(0, 20'd27,  1, 0, "start_ignored");

    // abort while idle must leave the last results untouched
    model(27, 20, 16, es, est, epk);
    @(negedge clk); abort_a[0] = 1'b1;
    @(posedge clk); #1; abort_a[0] = 1'b0;
    chk("idle_abort.busy",  busy_a[0],  0);
    chk("idle_abort.steps", steps_a[0], es);

    run_chk(0, 20'd3, 0, 1, "start_beats_abort");

    // abort at E10
    @(negedge clk); seed_a[0] = 20'd27; start_a[0] = 1'b1;
    @(posedge clk); #1; start_a[0] = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); abort_a[0] = 1'b1;
    @(posedge clk); #1; abort_a[0] = 1'b0;
    chk("abort.busy",   busy_a[0],   0);
    chk("abort.done",   done_a[0],   0);
    chk("abort.steps",  steps_a[0],  9);
    chk("abort.status", status_a[0], 0);
    any_done = 0;
    repeat (3) begin @(posedge clk); #1; any_done |= done_a[0]; end
    chk("abort.no_done", any_done, 0);
    run_chk(0, 20'd6, 0, 0, "restart_s6");

    // reset mid-run
    @(negedge clk); seed_a[0] = 20'd27; start_a[0] = 1'b1;
    @(posedge clk); #1; start_a[0] = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk); #2; rst_n = 1'b0; #1;
    chk("midrst.busy",   busy_a[0],   0);
    chk("midrst.done",   done_a[0],   0);
    chk("midrst.steps",  steps_a[0],  0);
    chk("midrst.status", status_a[0], 0);
`ifdef COLLATZ_PEAK_EN
    chk("midrst.peak",   peak_a[0],   0);
`endif
    any_done = 0;
    repeat (3) begin @(posedge clk); #1; any_done |= done_a[0]; end
    chk("midrst.no_done", any_done, 0);
    @(negedge clk); rst_n = 1'b1;
    run_chk(0, 20'd3, 0, 0, "after_rst_s3");

    for (int i = 0; i < 6; i++) begin
      run_chk(0, 20'($urandom_range(1, 20'hFFFFF)), 0, 0, $sformatf("rnd0_%0d", i));
      run_chk(1, 20'($urandom_range(0, 255)),       0, 0, $sformatf("rnd1_%0d", i));
      run_chk(2, 20'($urandom_range(1, 4095)),      0, 0, $sformatf("rnd2_%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
